// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage F/D/E/M/W pipeline: shadow E/M/W control state,
// operand forwarding selects, load-use stalls, taken-branch flushes and a hazard counter.
module hazard_controller #(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int CNT_W               = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [3:0]       ra1_d,
  input  logic [3:0]       ra2_d,
  input  logic [3:0]       wa_d,
  input  logic             reg_write_d,
  input  logic             mem_reg_d,
  input  logic             no_write_d,
  input  logic             branch_taken_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic [CNT_W-1:0] hazard_count
);

  localparam logic [1:0] LS_INIT = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
  localparam logic [1:0] BF_INIT = (BRANCH_FLUSH_CYCLES > 1) ? 2'(BRANCH_FLUSH_CYCLES - 2) : 2'd0;

  typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, BFLUSH = 2'd2} state_t;

  // r15 reads as PC+8, so it is never a forwarding target.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       m_v,
    input logic [3:0] m_wa,
    input logic       m_rw,
    input logic       m_mr,
    input logic       w_v,
    input logic [3:0] w_wa,
    input logic       w_rw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'hF) begin
      if (m_v && m_rw && !m_mr && (m_wa == ra))
        sel = 2'b10;
      else if (w_v && w_rw && (w_wa == ra))
        sel = 2'b01;
    end
    return sel;
  endfunction

  state_t     state;
  logic [1:0] cnt;

  logic       vld_p0, vld_p1, vld_p2;
  logic [3:0] wa_p0, ra1_p0, ra2_p0;
  logic       rw_p0, mr_p0;
  logic [3:0] wa_p1;
  logic       rw_p1, mr_p1;
  logic [3:0] wa_p2;
  logic       rw_p2;

  logic rw_d_eff, lu, br, stall;

  assign rw_d_eff = reg_write_d & ~no_write_d;
  assign lu = valid_d & vld_p0 & mr_p0 & rw_p0 & ((wa_p0 == ra1_d) | (wa_p0 == ra2_d));
  assign br = valid_d & branch_taken_d;

  // Stall/flush decode is Mealy so a load-use is held in the same cycle it is seen in D.
  always_comb begin
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    case (state)
      RUN: begin
        if (lu) begin
          stall   = 1'b1;
          flush_e = 1'b1;
        end else if (br) begin
          flush_d = 1'b1;
        end
      end
      LSTALL: begin
        stall   = 1'b1;
        flush_e = 1'b1;
      end
      BFLUSH: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_f = stall;
  assign stall_d = stall;

  assign forward_a_e = fwd_sel(ra1_p0, vld_p1, wa_p1, rw_p1, mr_p1, vld_p2, wa_p2, rw_p2);
  assign forward_b_e = fwd_sel(ra2_p0, vld_p1, wa_p1, rw_p1, mr_p1, vld_p2, wa_p2, rw_p2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= 2'd0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      hazard_count <= '0;
    end else begin
      vld_p0 <= valid_d & ~flush_e;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;

      case (state)
        RUN: begin
          if (lu) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state <= LSTALL;
              cnt   <= LS_INIT;
            end
          end else if (br) begin
            if (BRANCH_FLUSH_CYCLES > 1) begin
              state <= BFLUSH;
              cnt   <= BF_INIT;
            end
          end
        end
        LSTALL, BFLUSH: begin
          if (cnt == 2'd0)
            state <= RUN;
          else
            cnt <= cnt - 2'd1;
        end
        default: state <= RUN;
      endcase

      if ((stall | flush_d) && (hazard_count != {CNT_W{1'b1}}))
        hazard_count <= hazard_count + 1'b1;
    end
  end

  // D -> E (bubble on flush_e), E -> M, M -> W shadow fields.
  always_ff @(posedge clk) begin
    if (flush_e) begin
      wa_p0  <= 4'd0;
      rw_p0  <= 1'b0;
      mr_p0  <= 1'b0;
      ra1_p0 <= 4'd0;
      ra2_p0 <= 4'd0;
    end else begin
      wa_p0  <= wa_d;
      rw_p0  <= rw_d_eff;
      mr_p0  <= mem_reg_d;
      ra1_p0 <= ra1_d;
      ra2_p0 <= ra2_d;
    end
    wa_p1 <= wa_p0;
    rw_p1 <= rw_p0;
    mr_p1 <= mr_p0;
    wa_p2 <= wa_p1;
    rw_p2 <= rw_p1;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: hand-computed vector table, multi-cycle corner sequences,
// and random traffic against a queue-style pipeline model, on two parameter sets.
module tb_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid_d, reg_write_d, mem_reg_d, no_write_d, branch_taken_d;
  logic [3:0] ra1_d, ra2_d, wa_d;

  logic sf0, sd0, fd0, fe0;
  logic [1:0] fa0, fb0;
  logic [15:0] hc0;
  logic sf1, sd1, fd1, fe1;
  logic [1:0] fa1, fb1;
  logic [3:0] hc1;

  hazard_controller #(.LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa_d(wa_d),
    .reg_write_d(reg_write_d), .mem_reg_d(mem_reg_d), .no_write_d(no_write_d),
    .branch_taken_d(branch_taken_d), .stall_f(sf0), .stall_d(sd0), .flush_d(fd0),
    .flush_e(fe0), .forward_a_e(fa0), .forward_b_e(fb0), .hazard_count(hc0));

  hazard_controller #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa_d(wa_d),
    .reg_write_d(reg_write_d), .mem_reg_d(mem_reg_d), .no_write_d(no_write_d),
    .branch_taken_d(branch_taken_d), .stall_f(sf1), .stall_d(sd1), .flush_d(fd1),
    .flush_e(fe1), .forward_a_e(fa1), .forward_b_e(fb1), .hazard_count(hc1));

  typedef struct packed { bit v; bit [3:0] wa, ra1, ra2; bit rw, mr; } st_t;
  typedef struct { st_t e, m, w; int stall_left, flush_left, cnt; } mdl_t;
  typedef struct packed { logic sf, sd, fd, fe; logic [1:0] fa, fb; } out_t;
  typedef struct {
    logic v; logic [3:0] ra1, ra2, wa; logic rw, mr, nw, br;
    out_t exp; int cnt;
  } vec_t;

  mdl_t mdl [2];
  vec_t tbl [$];
  int checks = 0;
  int errors = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.e = '0; r.m = '0; r.w = '0;
    r.stall_left = 0; r.flush_left = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic bit lu_of(mdl_t s);
    return valid_d && s.e.v && s.e.mr && s.e.rw && (s.e.wa == ra1_d || s.e.wa == ra2_d);
  endfunction

  function automatic logic [1:0] fwd(mdl_t s, bit [3:0] r);
    if (r == 4'd15) return 2'd0;
    if (s.m.v && s.m.rw && !s.m.mr && s.m.wa == r) return 2'd2;
    if (s.w.v && s.w.rw && s.w.wa == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic out_t model_out(mdl_t s);
    out_t o;
    o = '0;
    if (s.stall_left > 0) begin o.sf = 1; o.sd = 1; o.fe = 1; end
    else if (s.flush_left > 0) begin o.fd = 1; o.fe = 1; end
    else if (lu_of(s)) begin o.sf = 1; o.sd = 1; o.fe = 1; end
    else if (valid_d && branch_taken_d) o.fd = 1;
    o.fa = fwd(s, s.e.ra1);
    o.fb = fwd(s, s.e.ra2);
    return o;
  endfunction

  function automatic mdl_t model_next(mdl_t s, int lsc, int bfc, int cmax);
    mdl_t n;
    out_t o;
    st_t d;
    if (rst) return mdl_reset();
    n = s;
    o = model_out(s);
    d.v = valid_d; d.wa = wa_d; d.ra1 = ra1_d; d.ra2 = ra2_d;
    d.rw = reg_write_d && !no_write_d; d.mr = mem_reg_d;
    n.w = s.m;
    n.m = s.e;
    n.e = o.fe ? st_t'('0) : d;
    if (s.stall_left > 0) n.stall_left = s.stall_left - 1;
    else if (s.flush_left > 0) n.flush_left = s.flush_left - 1;
    else if (lu_of(s)) n.stall_left = lsc - 1;
    else if (valid_d && branch_taken_d) n.flush_left = bfc - 1;
    if ((o.sd || o.fd) && s.cnt < cmax) n.cnt = s.cnt + 1;
    return n;
  endfunction

  task automatic drive(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] w, input logic rw, input logic mr,
                       input logic nw, input logic br);
    valid_d = v; ra1_d = r1; ra2_d = r2; wa_d = w;
    reg_write_d = rw; mem_reg_d = mr; no_write_d = nw; branch_taken_d = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_models();
    out_t o, a;
    if (rst) return;
    o = model_out(mdl[0]);
    a = {sf0, sd0, fd0, fe0, fa0, fb0};
    checks++;
    if (a !== o || hc0 !== 16'(mdl[0].cnt)) begin
      errors++;
      $display("FAIL model0 t=%0t out=%b exp=%b count=%0d exp=%0d", $time, a, o, hc0, mdl[0].cnt);
    end
    o = model_out(mdl[1]);
    a = {sf1, sd1, fd1, fe1, fa1, fb1};
    checks++;
    if (a !== o || hc1 !== 4'(mdl[1].cnt)) begin
      errors++;
      $display("FAIL model1 t=%0t out=%b exp=%b count=%0d exp=%0d", $time, a, o, hc1, mdl[1].cnt);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    mdl[0] = model_next(mdl[0], 1, 2, 65535);
    mdl[1] = model_next(mdl[1], 3, 3, 15);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_models();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    advance();
    advance();
    rst = 1'b0;
  endtask

  function automatic void add(logic v, logic [3:0] r1, logic [3:0] r2, logic [3:0] w,
                              logic rw, logic mr, logic nw, logic br, logic [7:0] e, int c);
    vec_t t;
    t.v = v; t.ra1 = r1; t.ra2 = r2; t.wa = w; t.rw = rw; t.mr = mr; t.nw = nw; t.br = br;
    t.exp = out_t'(e); t.cnt = c;
    tbl.push_back(t);
  endfunction

  initial begin
    out_t a;
    logic [4:0] fd0_seq, fd1_seq;
    mdl[0] = mdl_reset();
    mdl[1] = mdl_reset();
    do_reset();

    // Reset state
    nop();
    @(negedge clk);
    checks++;
    if ({sf0, sd0, fd0, fe0, fa0, fb0, hc0} !== 24'd0 || {sf1, sd1, fd1, fe1, fa1, fb1, hc1} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state dut0=%b dut1=%b want zeros", {sf0, sd0, fd0, fe0, fa0, fb0, hc0},
               {sf1, sd1, fd1, fe1, fa1, fb1, hc1});
    end
    check_models();
    advance();

    // exp bits: {stall_f, stall_d, flush_d, flush_e, fwd_a[1:0], fwd_b[1:0]}
    add(1, 1, 2, 3, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 3, 7, 6, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_10_00, 0);
    add(1, 1, 2, 5, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 1, 2, 8, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 1, 5, 9, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_01, 0);
    add(1, 1, 2, 5, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 1, 2, 5, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 1, 5, 10, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_10, 0);
    add(1, 1, 2, 4, 1, 0, 1, 0, 8'b0000_00_00, 0);
    add(1, 4, 4, 11, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 1, 2, 15, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 15, 15, 12, 1, 0, 0, 0, 8'b0000_00_00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00, 0);
    add(1, 1, 3, 2, 1, 1, 0, 0, 8'b0000_00_00, 0);
    add(1, 2, 7, 13, 1, 0, 0, 0, 8'b1101_00_00, 0);
    add(1, 2, 7, 13, 1, 0, 0, 0, 8'b0000_00_00, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_01_00, 1);
    add(1, 1, 2, 0, 0, 0, 0, 1, 8'b0010_00_00, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0011_00_00, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00, 3);
    add(1, 1, 3, 6, 1, 1, 0, 0, 8'b0000_00_00, 3);
    add(1, 6, 2, 0, 0, 0, 0, 1, 8'b1101_00_00, 3);
    add(1, 6, 2, 0, 0, 0, 0, 1, 8'b0010_00_00, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0011_01_00, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00, 6);
    add(0, 3, 4, 0, 0, 0, 0, 1, 8'b0000_00_00, 6);
    add(1, 1, 2, 7, 1, 1, 0, 0, 8'b0000_00_00, 6);
    add(0, 7, 7, 0, 0, 0, 0, 0, 8'b0000_00_00, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00, 6);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].ra1, tbl[i].ra2, tbl[i].wa, tbl[i].rw, tbl[i].mr, tbl[i].nw, tbl[i].br);
      @(negedge clk);
      a = {sf0, sd0, fd0, fe0, fa0, fb0};
      checks++;
      if (a !== tbl[i].exp || hc0 !== 16'(tbl[i].cnt)) begin
        errors++;
        $display("FAIL vec%0d out=%b exp=%b count=%0d exp=%0d", i, a, tbl[i].exp, hc0, tbl[i].cnt);
      end
      check_models();
      advance();
    end

    // Reset in the middle of a 3-cycle load stall
    do_reset();
    drive(1, 1, 3, 2, 1, 1, 0, 0);
    cyc();
    drive(1, 2, 7, 13, 1, 0, 0, 0);
    cyc();
    @(negedge clk);
    checks++;
    if (sd1 !== 1'b1 || fe1 !== 1'b1) begin
      errors++;
      $display("FAIL lstall_hold stall_d=%b flush_e=%b want 1 1", sd1, fe1);
    end
    check_models();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    nop();
    @(negedge clk);
    checks++;
    if ({sf1, sd1, fd1, fe1, fa1, fb1, hc1} !== 12'd0 || {sf0, sd0, fd0, fe0} !== 4'd0) begin
      errors++;
      $display("FAIL rst_in_lstall dut1=%b dut0=%b want zeros", {sf1, sd1, fd1, fe1, fa1, fb1, hc1},
               {sf0, sd0, fd0, fe0});
    end
    check_models();
    advance();

    // Flush length of one taken branch for both parameter sets
    do_reset();
    fd0_seq = '0;
    fd1_seq = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, 1, 2, 0, 0, 0, 0, 1);
      else nop();
      @(negedge clk);
      fd0_seq[4-i] = fd0;
      fd1_seq[4-i] = fd1;
      check_models();
      advance();
    end
    checks++;
    if (fd0_seq !== 5'b11000 || fd1_seq !== 5'b11100) begin
      errors++;
      $display("FAIL flush_len dut0=%b want 11000 dut1=%b want 11100", fd0_seq, fd1_seq);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      cyc();
    end
    rst = 1'b0;

    // Counter saturation
    do_reset();
    drive(1, 1, 2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 70000; i++) cyc();
    @(negedge clk);
    checks++;
    if (hc0 !== 16'hFFFF || hc1 !== 4'hF) begin
      errors++;
      $display("FAIL saturate count0=%h want ffff count1=%h want f", hc0, hc1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
